// File: rtl/dcp_pkg.sv
// Shared constants for the debug control port: FSM state encoding, ASCII codes, print request types.
package dcp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam logic TX_CHAR = 1'b0;
  localparam logic TX_HEX  = 1'b1;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational 4-bit value to uppercase ASCII hex digit.
module nibble_to_ascii
  import dcp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  always_comb begin
    if (nib < 4'd10) chr = ASCII_0 + {4'h0, nib};
    else             chr = ASCII_A + {4'h0, nib - 4'd10};
  end

endmodule

// File: rtl/dcp_tx_formatter.sv
// Debug-port transmit formatter: prints a raw char or a hex word as a valid/ready byte stream.
// Define DCP_TX_HEX_CRLF_EN to append CR LF after every hex word.
module dcp_tx_formatter
  import dcp_pkg::*;
#(
  parameter int HEX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] dout_tx,
  output logic        ack_tx,
  output logic [7:0]  d_tx,
  output logic        vld_tx,
  input  logic        rdy_tx
);

`ifdef DCP_TX_HEX_CRLF_EN
  localparam logic [3:0] HEX_LEN = 4'(HEX_DIGITS + 2);
`else
  localparam logic [3:0] HEX_LEN = 4'(HEX_DIGITS);
`endif

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        type_q, type_d;
  logic        vld_q, vld_d;
  logic        ack_q, ack_d;
  logic [7:0]  d_tx_q, d_tx_d;
  logic        load_byte;
  logic [3:0]  nib_idx;
  logic [3:0]  nib;
  logic [7:0]  nib_chr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    type_d    = type_q;
    vld_d     = vld_q;
    ack_d     = 1'b0;
    load_byte = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_tx) begin
          state_d   = ST_SEND;
          data_d    = dout_tx;
          type_d    = type_tx;
          cnt_d     = (type_tx == TX_HEX) ? HEX_LEN : 4'd1;
          vld_d     = 1'b1;
          load_byte = 1'b1;
        end
      end
      ST_SEND: begin
        if (rdy_tx) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_d == 4'd0) begin
            state_d = ST_ACK;
            vld_d   = 1'b0;
            ack_d   = 1'b1;
          end else begin
            load_byte = 1'b1;
          end
        end
      end
      ST_ACK:     state_d = ST_RELEASE;
      ST_RELEASE: if (!req_tx) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // The byte for the next cycle is chosen from the next count, so d_tx stays registered.
`ifdef DCP_TX_HEX_CRLF_EN
  assign nib_idx = cnt_d - 4'd3;
`else
  assign nib_idx = cnt_d - 4'd1;
`endif
  assign nib = 4'(data_d >> {nib_idx, 2'b00});

  nibble_to_ascii u_nib (
    .nib (nib),
    .chr (nib_chr)
  );

  always_comb begin
    d_tx_d = d_tx_q;
    if (load_byte) begin
      if (type_d == TX_CHAR)   d_tx_d = data_d[7:0];
`ifdef DCP_TX_HEX_CRLF_EN
      else if (cnt_d == 4'd2) d_tx_d = ASCII_CR;
      else if (cnt_d == 4'd1) d_tx_d = ASCII_LF;
`endif
      else                     d_tx_d = nib_chr;
    end else if (ack_d) begin
      d_tx_d = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      data_q  <= 32'd0;
      type_q  <= TX_CHAR;
      vld_q   <= 1'b0;
      ack_q   <= 1'b0;
      d_tx_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      type_q  <= type_d;
      vld_q   <= vld_d;
      ack_q   <= ack_d;
      d_tx_q  <= d_tx_d;
    end
  end

  assign ack_tx = ack_q;
  assign vld_tx = vld_q;
  assign d_tx   = d_tx_q;

endmodule
